// File: rtl/bit_serial_sched_if.sv
// Handshake bundle between the round scheduler and the bit-serial datapath.
// master = scheduler side, slave = command source / datapath side.
interface bit_serial_sched_if #(
    parameter int COMPUTE_CYCLE = 8,
    parameter int ROUND_WIDTH   = 8
);
    localparam int IW = $clog2(COMPUTE_CYCLE);

    logic                   cmd_vld;
    logic                   cmd_rdy;
    logic [ROUND_WIDTH-1:0] cmd_rounds;
    logic                   plane_vld;
    logic                   plane_rdy;
    logic [IW-1:0]          plane_idx;
    logic                   plane_first;
    logic                   plane_last;
    logic                   acc_fire;

    modport master (
        input  cmd_vld, cmd_rounds, plane_rdy, acc_fire,
        output cmd_rdy, plane_vld, plane_idx, plane_first, plane_last
    );

    modport slave (
        output cmd_vld, cmd_rounds, plane_rdy, acc_fire,
        input  cmd_rdy, plane_vld, plane_idx, plane_first, plane_last
    );
endinterface

// File: rtl/bit_serial_sched.sv
// Round scheduler: streams bit-plane indices per round under a credit limit
// on accumulator results still in flight, and signals job completion.
module bit_serial_sched #(
    parameter int COMPUTE_CYCLE = 8,
    parameter int ROUND_WIDTH   = 8,
    parameter int CREDIT        = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    bit_serial_sched_if.master     bus,
    output logic                   busy,
    output logic                   done,
    output logic [ROUND_WIDTH-1:0] rounds_done,
    output logic                   err
);
    localparam int IW = $clog2(COMPUTE_CYCLE);
    localparam int OW = $clog2(CREDIT + 1);
    localparam int RW = ROUND_WIDTH;

    localparam logic [IW-1:0] LAST = IW'(COMPUTE_CYCLE - 1);
    localparam logic [OW-1:0] CRED = OW'(CREDIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [RW-1:0] tgt;
    logic [RW-1:0] issued;
    logic [RW-1:0] rounds_done_n;
    logic [OW-1:0] outstanding;
    logic [IW-1:0] idx;
    logic          cmd_fire;
    logic          plane_fire;
    logic          last_fire;
    logic          acc_ok;

    assign cmd_fire = (state == IDLE) & bus.cmd_vld;

    // Credit gating only at round start; a started round always streams out.
    assign bus.plane_vld = (state == ISSUE)
                         & ((idx != '0) | (outstanding < CRED));

    assign plane_fire    = bus.plane_vld & bus.plane_rdy;
    assign last_fire     = plane_fire & (idx == LAST);
    assign acc_ok        = bus.acc_fire & (outstanding != '0);
    assign rounds_done_n = rounds_done + RW'(acc_ok);

    assign bus.cmd_rdy     = (state == IDLE);
    assign bus.plane_idx   = idx;
    assign bus.plane_first = (idx == '0);
    assign bus.plane_last  = (idx == LAST);
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (cmd_fire)
                    state_n = (bus.cmd_rounds != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                if (last_fire && (issued + 1'b1 == tgt))
                    state_n = DRAIN;
            end
            DRAIN: begin
                if (rounds_done_n == tgt)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tgt         <= '0;
            issued      <= '0;
            rounds_done <= '0;
            outstanding <= '0;
            idx         <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_n;
            if (cmd_fire) begin
                tgt         <= bus.cmd_rounds;
                issued      <= '0;
                rounds_done <= '0;
                idx         <= '0;
                err         <= 1'b0;
            end else begin
                if (plane_fire)
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                if (last_fire)
                    issued <= issued + 1'b1;
                rounds_done <= rounds_done_n;
                if (bus.acc_fire && (outstanding == '0))
                    err <= 1'b1;
            end
            // Issue and return in one cycle cancel out.
            unique case ({last_fire, acc_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_sched.sv
// Bench for bit_serial_sched: job-level reference model checked every cycle,
// a table of whole-job vectors, directed corner sequences and random traffic.
module tb_bit_serial_sched;
    localparam int CC     = 8;
    localparam int RW     = 8;
    localparam int CREDIT = 2;

    logic          clk;
    logic          rst;
    logic          busy;
    logic          done;
    logic [RW-1:0] rounds_done;
    logic          err;

    bit_serial_sched_if #(.COMPUTE_CYCLE(CC), .ROUND_WIDTH(RW)) bus ();

    bit_serial_sched #(
        .COMPUTE_CYCLE(CC),
        .ROUND_WIDTH(RW),
        .CREDIT(CREDIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .done(done),
        .rounds_done(rounds_done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Job-level model: progress counted in planes and returned rounds.
    typedef struct {
        bit in_job;
        bit done_c;
        int rounds;
        int planes;
        int ret;
        bit err;
    } mdl_t;

    mdl_t m;

    function automatic int m_out(mdl_t x);
        return x.planes / CC - x.ret;
    endfunction

    function automatic bit m_vld(mdl_t x);
        bit more;
        bit room;
        more = x.planes < x.rounds * CC;
        room = (x.planes % CC != 0) || (m_out(x) < CREDIT);
        return x.in_job && more && room;
    endfunction

    function automatic mdl_t m_step(mdl_t x, bit cv, int cr, bit rdy, bit acc);
        mdl_t n;
        n = x;
        n.done_c = 1'b0;
        if (acc) begin
            if (m_out(x) > 0) n.ret++;
            else n.err = 1'b1;
        end
        if (m_vld(x) && rdy) n.planes++;
        if (!(x.in_job || x.done_c) && cv) begin
            n.rounds = cr;
            n.planes = 0;
            n.ret    = 0;
            n.err    = 1'b0;
            if (cr == 0) n.done_c = 1'b1;
            else n.in_job = 1'b1;
        end else if (x.in_job && n.planes == n.rounds * CC && n.ret == n.rounds) begin
            n.in_job = 1'b0;
            n.done_c = 1'b1;
        end
        return n;
    endfunction

    function automatic mdl_t m_reset();
        mdl_t n;
        n.in_job = 0; n.done_c = 0; n.rounds = 0;
        n.planes = 0; n.ret = 0; n.err = 0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= m_reset();
        else m <= m_step(m, bus.cmd_vld, int'(bus.cmd_rounds),
                         bus.plane_rdy, bus.acc_fire);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_model();
        int eidx;
        eidx = m.planes % CC;
        chk("m_plane_vld", bus.plane_vld, m_vld(m));
        chk("m_plane_idx", bus.plane_idx, eidx);
        chk("m_plane_first", bus.plane_first, eidx == 0);
        chk("m_plane_last", bus.plane_last, eidx == CC - 1);
        chk("m_busy", busy, m.in_job || m.done_c);
        chk("m_cmd_rdy", bus.cmd_rdy, !(m.in_job || m.done_c));
        chk("m_done", done, m.done_c);
        chk("m_rounds_done", rounds_done, m.ret);
        chk("m_err", err, m.err);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        cmp_model();
    endtask

    task automatic start_job(input int r);
        for (int i = 0; i < 50 && !bus.cmd_rdy; i++) tick();
        chk("start_cmd_rdy", bus.cmd_rdy, 1);
        bus.cmd_vld    = 1'b1;
        bus.cmd_rounds = RW'(r);
        tick();
        bus.cmd_vld = 1'b0;
    endtask

    task automatic drain_job();
        int k;
        for (k = 0; k < 300; k++) begin
            if (done) break;
            bus.plane_rdy = 1'b1;
            bus.acc_fire  = m_out(m) > 0;
            tick();
        end
        bus.acc_fire = 1'b0;
        chk("drain_done", done, 1);
        tick();
    endtask

    task automatic run_job(input int r, input int d,
                           output int planes, output int firsts,
                           output int lasts, output int seqerr,
                           output int done_edge, output int last_acc);
        int pend[$];
        bit acc;
        planes = 0; firsts = 0; lasts = 0; seqerr = 0; done_edge = -1;
        bus.plane_rdy = 1'b1;
        start_job(r);
        last_acc = cyc;
        for (int k = 0; k < 600; k++) begin
            if (done) begin
                done_edge = cyc;
                break;
            end
            if (bus.plane_vld && bus.plane_rdy) begin
                if (int'(bus.plane_idx) != planes % CC) seqerr++;
                planes++;
                if (bus.plane_first) firsts++;
                if (bus.plane_last) begin
                    lasts++;
                    pend.push_back(cyc + 1 + d);
                end
            end
            acc = (pend.size() > 0) && (pend[0] == cyc + 1);
            if (acc) begin
                void'(pend.pop_front());
                last_acc = cyc + 1;
            end
            bus.acc_fire = acc;
            tick();
        end
        bus.acc_fire = 1'b0;
    endtask

    typedef struct {
        int rounds;
        int delay;
        int exp_planes;
        int exp_firsts;
        int exp_lasts;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pl, fi, la, se, de, lac, cnt;

        tbl[0] = '{3, 2, 24, 3, 3};
        tbl[1] = '{1, 1, 8, 1, 1};
        tbl[2] = '{4, 3, 32, 4, 4};
        tbl[3] = '{3, 12, 24, 3, 3};
        tbl[4] = '{0, 1, 0, 0, 0};

        bus.cmd_vld = 0; bus.cmd_rounds = 0;
        bus.plane_rdy = 0; bus.acc_fire = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        cmp_model();
        chk("rst_cmd_rdy", bus.cmd_rdy, 1);
        chk("rst_plane_vld", bus.plane_vld, 0);
        chk("rst_plane_first", bus.plane_first, 1);
        chk("rst_busy", busy, 0);
        chk("rst_outstanding", dut.outstanding, 0);

        // Whole-job vectors.
        foreach (tbl[i]) begin
            run_job(tbl[i].rounds, tbl[i].delay, pl, fi, la, se, de, lac);
            chk("tbl_planes", pl, tbl[i].exp_planes);
            chk("tbl_firsts", fi, tbl[i].exp_firsts);
            chk("tbl_lasts", la, tbl[i].exp_lasts);
            chk("tbl_idx_seq", se, 0);
            chk("tbl_rounds_done", rounds_done, tbl[i].rounds);
            chk("tbl_done_latency", de, lac);
            tick();
            chk("tbl_cmd_rdy_after", bus.cmd_rdy, 1);
        end

        // Credit stall: two rounds unreturned block the third.
        bus.plane_rdy = 1'b1;
        start_job(3);
        chk("first_plane_vld", bus.plane_vld, 1);
        chk("first_plane_idx", bus.plane_idx, 0);
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 2 * CC; k++) begin
            if (bus.plane_vld) cnt++;
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            chk("stall_plane_vld", bus.plane_vld, 0);
            tick();
        end
        bus.acc_fire = 1'b1;
        tick();
        bus.acc_fire = 1'b0;
        chk("stall_resume_vld", bus.plane_vld, 1);
        chk("stall_resume_idx", bus.plane_idx, 0);
        drain_job();

        // Mid-round backpressure at index 3.
        start_job(1);
        for (int k = 0; k < 20 && bus.plane_idx != 3; k++) tick();
        bus.plane_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_hold_idx", bus.plane_idx, 3);
            chk("bp_hold_vld", bus.plane_vld, 1);
        end
        bus.plane_rdy = 1'b1;
        tick();
        chk("bp_next_idx", bus.plane_idx, 4);
        cnt = 4;
        for (int k = 0; k < 20; k++) begin
            if (bus.plane_vld && bus.plane_rdy) cnt++;
            tick();
        end
        chk("bp_plane_count", cnt, CC);
        drain_job();

        // Return of round 1 coincides with round 2's sign plane.
        start_job(2);
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 2 * CC - 1; k++) begin
            if (bus.plane_vld && bus.plane_rdy) cnt++;
            tick();
        end
        chk("sim_at_last", bus.plane_last, 1);
        bus.acc_fire = 1'b1;
        tick();
        bus.acc_fire = 1'b0;
        chk("sim_outstanding", dut.outstanding, 1);
        chk("sim_rounds_done", rounds_done, 1);
        drain_job();

        // Spurious return while idle.
        bus.acc_fire = 1'b1;
        tick();
        bus.acc_fire = 1'b0;
        chk("spur_err_set", err, 1);
        start_job(1);
        chk("spur_err_clear", err, 0);
        drain_job();

        // Reset during round 2 of 4.
        start_job(4);
        for (int k = 0; k < 12; k++) begin
            bus.acc_fire = (m_out(m) > 0) && (k % 5 == 4);
            tick();
        end
        bus.acc_fire = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_cmd_rdy", bus.cmd_rdy, 1);
        chk("mr_plane_vld", bus.plane_vld, 0);
        chk("mr_plane_idx", bus.plane_idx, 0);
        chk("mr_plane_first", bus.plane_first, 1);
        chk("mr_plane_last", bus.plane_last, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_rounds_done", rounds_done, 0);
        chk("mr_err", err, 0);
        chk("mr_outstanding", dut.outstanding, 0);
        tick();
        chk("mr_no_done", done, 0);
        rst = 1'b0;
        tick();
        chk("mr_no_done2", done, 0);
        run_job(1, 2, pl, fi, la, se, de, lac);
        chk("mr_job_planes", pl, CC);
        chk("mr_job_rounds", rounds_done, 1);
        chk("mr_job_done", de, lac);
        tick();

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            bus.cmd_vld    = $urandom_range(0, 1);
            bus.cmd_rounds = RW'($urandom_range(0, 5));
            bus.plane_rdy  = $urandom_range(0, 9) < 7;
            bus.acc_fire   = ((m_out(m) > 0) && ($urandom_range(0, 9) < 3))
                           || ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        bus.cmd_vld  = 1'b0;
        bus.acc_fire = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_serial_sched.md
# bit_serial_sched

Round scheduler for the bit-serial accumulation path. Accepts a job command giving a round count, then sequences bit-plane indices (LSB first, sign plane last) to the bit-serial MAC/adder-tree front end, one plane per handshake. It limits the number of rounds in flight using a credit count of accumulator results not yet returned. It reports completion once every issued round has come back from the accumulator output handshake.

## Interface
- `COMPUTE_CYCLE`, 8: bit planes per round (operand bit width); must be ≥2.
- `ROUND_WIDTH`, 8: width of the round count; a job has at most 2^ROUND_WIDTH−1 rounds.
- `CREDIT`, 2: maximum rounds issued but not yet returned; must be ≥1.
- `clk` in 1: the single clock; all logic is posedge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_vld` in 1: a job command is valid.
- `cmd_rdy` out 1: the scheduler can accept a command.
- `cmd_rounds` in ROUND_WIDTH: round count for the job; sampled on command fire.
- `plane_vld` out 1: a plane issue is valid.
- `plane_rdy` in 1: the downstream datapath accepts the plane.
- `plane_idx` out $clog2(COMPUTE_CYCLE): bit-plane index, 0..COMPUTE_CYCLE−1.
- `plane_first` out 1: `plane_idx`==0. Tells the datapath to restart accumulation.
- `plane_last` out 1: `plane_idx`==COMPUTE_CYCLE−1. Marks the sign plane, which the datapath subtracts.
- `acc_fire` in 1: one accumulator result was transferred (accumulator valid AND ready).
- `busy` out 1: the state is not IDLE.
- `done` out 1: one-cycle pulse at job completion.
- `rounds_done` out ROUND_WIDTH: rounds returned so far in the current or last job.
- `err` out 1: sticky flag for `acc_fire` while the outstanding count is 0.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - `cmd_rdy`=1.
  - On command fire: latch `cmd_rounds` into `tgt`; clear `issued`, `rounds_done`, `plane_idx` and `err`.
  - Next state is ISSUE if `cmd_rounds`≠0, otherwise DONE.
- ISSUE
  - `plane_vld`=1 when `plane_idx`≠0, or when `outstanding`<CREDIT.
  - The credit check applies only at round start. Once plane 0 is accepted, the round streams without any credit gating.
  - On a plane fire, `plane_idx` increments. It wraps to 0 after COMPUTE_CYCLE−1.
  - On a fire with `plane_last`=1: `issued`+=1 and `outstanding`+=1. If `issued`+1==`tgt`, the next state is DRAIN.
  - If `plane_rdy`=0, `plane_vld` and `plane_idx` hold. A mid-round stall never drops a plane and never advances the index.
- DRAIN
  - `plane_vld`=0.
  - When `rounds_done` reaches `tgt` (including on the cycle of the final `acc_fire`), the next state is DONE.
- DONE
  - `done`=1 for exactly one cycle, then the FSM returns to IDLE.
- `acc_fire` handling (in any state, when `outstanding`>0)
  - `outstanding`−=1 and `rounds_done`+=1.
  - If a last-plane fire and `acc_fire` occur in the same cycle, `outstanding` is unchanged and both `issued` and `rounds_done` increment.
- `acc_fire` with `outstanding`==0 sets `err` and changes no counter.
- `cmd_rdy`=0 outside IDLE; commands are never queued.
- Counter widths
  - `outstanding` is $clog2(CREDIT+1) bits and never exceeds CREDIT.
  - `issued` and `rounds_done` are ROUND_WIDTH bits and never wrap within a job.

## Timing
- Reset values: FSM=IDLE, `cmd_rdy`=1, `plane_vld`=0, `plane_idx`=0, `plane_first`=1, `plane_last`=0, `busy`=0, `done`=0, `rounds_done`=0, `err`=0, `outstanding`=0.
- Asserting `rst` mid-job aborts the job immediately: all state returns to reset values, and no `done` pulse is produced.
- Output timing
  - All outputs are functions of registered state only.
  - There is no combinational path from `plane_rdy`, `cmd_vld` or `acc_fire` to any output.
- Latency from command to first plane: command fire at cycle T puts `plane_vld`=1 with `plane_idx`=0 at T+1.
- Throughput
  - With `plane_rdy`=1 and credit available, one plane is issued per cycle, back-to-back across rounds.
  - A job of R rounds occupies R·COMPUTE_CYCLE issue cycles minimum.
- Credit stall: `outstanding`==CREDIT at a round start forces `plane_vld`=0 until an `acc_fire`. `plane_vld` rises in the cycle after that `acc_fire`.
- Completion latency
  - The final `acc_fire` at cycle T gives `done`=1 at T+1 and `cmd_rdy`=1 at T+2.
  - A zero-round command fired at T gives `done` at T+1.
- `busy`=1 from T+1 after command fire through the DONE cycle inclusive.

## Test plan
- Basic job: CREDIT=2, `cmd_rounds`=3, `plane_rdy`=1, and `acc_fire` is pulsed 2 cycles after each last-plane fire.
  - Required: 24 planes with `plane_idx` sequence 0..7 repeated.
  - Required: `plane_first`/`plane_last` asserted at indices 0 and 7.
  - Required: `done` 1 cycle after the third `acc_fire`, with `rounds_done`=3.
- Credit stall: CREDIT=1, 2 rounds, first `acc_fire` withheld for 10 cycles.
  - Required: `plane_vld`=0 after the 8th plane until the cycle after `acc_fire`.
  - Required: then `plane_idx`=0 resumes.
- Mid-round backpressure: drop `plane_rdy` while `plane_idx`=3 for 4 cycles.
  - Required: `plane_idx` holds at 3 with `plane_vld`=1, then continues to 4.
  - Required: the total plane count stays 8 per round.
- Simultaneous events: `acc_fire` in the same cycle as the second round's last-plane fire (CREDIT=2).
  - Required: `outstanding` stays 1 and `rounds_done`=1.
- Boundary commands
  - `cmd_rounds`=0: `done` at T+1, no `plane_vld` ever, `rounds_done`=0.
  - Spurious `acc_fire` while in IDLE: `err`=1, which clears on the next command fire.
- Reset mid-job: assert `rst` during round 2 of 4.
  - Required: all outputs at reset values immediately, and no `done` pulse.
  - Required: a following job of 1 round completes normally.
